// File: rtl/updown_counter_mod_pkg.sv
// Shared constants and parameter-legality helper for the up/down counter.
package updown_counter_mod_pkg;

   localparam int unsigned CNT_WRAP = 0;
   localparam int unsigned CNT_SAT  = 1;

   // True when the parameter set describes a buildable counter.
   function automatic bit cnt_params_legal(input int unsigned     width,
                                           input longint unsigned modulo,
                                           input int unsigned     prescale,
                                           input int unsigned     saturate);
      longint unsigned span;
      span = longint'(1) << width;
      return (width >= 1) && (width <= 32) && (modulo >= 2) && (modulo <= span) &&
             (prescale >= 1) && (saturate <= CNT_SAT);
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Counts enabled cycles and emits a step on the last cycle of each interval.
module counter_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc_q, psc_d;

   // With PRESCALE=1 LAST is zero, psc never leaves 0 and step follows enable.
   assign step = enable && (psc_q == LAST);

   // Next interval position: restart on clear, hold while disabled.
   always_comb begin
      psc_d = psc_q;
      if (clear) begin
         psc_d = '0;
      end else if (enable) begin
         psc_d = (psc_q == LAST) ? '0 : psc_q + PSC_W'(1);
      end
   end

   // Interval position register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) psc_q <= '0;
      else        psc_q <= psc_d;
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with wrap or saturate ends, load, clear, prescaler and flags.
module updown_counter_mod
   import updown_counter_mod_pkg::*;
#(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MODULO   = 16,
   parameter int unsigned     PRESCALE = 1,
   parameter int unsigned     SATURATE = CNT_WRAP
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             load_err
);

   // One extra bit so MODULO == 2**WIDTH is representable.
   localparam int unsigned      CW    = WIDTH + 1;
   localparam logic [CW-1:0]    MOD_C = CW'(MODULO);
   localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULO - 1);
   localparam bit               SAT   = (SATURATE == CNT_SAT);

   if (!cnt_params_legal(WIDTH, MODULO, PRESCALE, SATURATE)) begin : g_param_err
      $error("updown_counter_mod: illegal WIDTH/MODULO/PRESCALE/SATURATE");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             lerr_q, lerr_d;
   logic             step;
   logic [CW-1:0]    cnt_ext;
   logic [CW-1:0]    ld_ext;

   assign cnt_ext = {1'b0, count_q};
   assign ld_ext  = {1'b0, load_val};

   // Load also restarts the interval so a loaded value gets a full period.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_psc (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .clear  (clear | load),
      .step   (step)
   );

   // Terminal count from the registered count and the live direction.
   always_comb begin
      tc = up ? (count_q == TOP) : (count_q == '0);
   end

   // Next count and flags; priority clear > load > step.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      lerr_d  = 1'b0;
      if (clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         if (ld_ext < MOD_C) begin
            count_d = load_val;
         end else begin
            count_d = TOP;
            lerr_d  = 1'b1;
         end
      end else if (step) begin
         if (up) begin
            if (count_q == TOP) begin
               count_d = SAT ? count_q : '0;
               wrap_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = WIDTH'(cnt_ext + CW'(1));
            end
         end else begin
            if (count_q == '0) begin
               count_d = SAT ? count_q : TOP;
               wrap_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = WIDTH'(cnt_ext - CW'(1));
            end
         end
      end
   end

   // Count and flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
         lerr_q  <= lerr_d;
      end
   end

   assign count    = count_q;
   assign wrap     = wrap_q;
   assign ovf      = ovf_q;
   assign load_err = lerr_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench: four counter variants share one input stream and are compared each cycle.
module tb_updown_counter_mod;

   // Instance 0: M10 wrap, 1: M10 saturate, 2: M10 prescale 3, 3: M16 wrap.
   logic       clock;
   logic       reset;
   logic       clear;
   logic       load;
   logic [3:0] load_val;
   logic       enable;
   logic       up;
   logic [3:0] cnt_w  [4];
   logic       tc_w   [4];
   logic       wrap_w [4];
   logic       ovf_w  [4];
   logic       lerr_w [4];

   int  n_total = 0;
   int  n_pass  = 0;
   bit  chk_on  = 0;

   int  m_cnt  [4];
   int  m_psc  [4];
   bit  m_wrap [4];
   bit  m_ovf  [4];
   bit  m_lerr [4];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   updown_counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) u_a (
      .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up(up), .count(cnt_w[0]), .tc(tc_w[0]), .wrap(wrap_w[0]),
      .ovf(ovf_w[0]), .load_err(lerr_w[0]));
   updown_counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) u_b (
      .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up(up), .count(cnt_w[1]), .tc(tc_w[1]), .wrap(wrap_w[1]),
      .ovf(ovf_w[1]), .load_err(lerr_w[1]));
   updown_counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(3), .SATURATE(0)) u_c (
      .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up(up), .count(cnt_w[2]), .tc(tc_w[2]), .wrap(wrap_w[2]),
      .ovf(ovf_w[2]), .load_err(lerr_w[2]));
   updown_counter_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(1), .SATURATE(0)) u_d (
      .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up(up), .count(cnt_w[3]), .tc(tc_w[3]), .wrap(wrap_w[3]),
      .ovf(ovf_w[3]), .load_err(lerr_w[3]));

   function automatic int mod_of(input int k);
      return (k == 3) ? 16 : 10;
   endfunction
   function automatic int psc_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction
   function automatic bit sat_of(input int k);
      return (k == 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: counts as integers following the counter rules.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            m_cnt[k] <= 0; m_psc[k] <= 0; m_wrap[k] <= 0; m_ovf[k] <= 0; m_lerr[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int c, p;
            bit w, o, e;
            c = m_cnt[k]; p = m_psc[k]; o = m_ovf[k]; w = 0; e = 0;
            if (clear) begin
               c = 0; p = 0; o = 0;
            end else if (load) begin
               p = 0;
               if (int'(load_val) < mod_of(k)) c = int'(load_val);
               else begin c = mod_of(k) - 1; e = 1; end
            end else if (enable) begin
               if (p == psc_of(k) - 1) begin
                  p = 0;
                  if (up) begin
                     if (c == mod_of(k) - 1) begin w = 1; o = 1; if (!sat_of(k)) c = 0; end
                     else c = c + 1;
                  end else begin
                     if (c == 0) begin w = 1; o = 1; if (!sat_of(k)) c = mod_of(k) - 1; end
                     else c = c - 1;
                  end
               end else begin
                  p = p + 1;
               end
            end
            m_cnt[k] <= c; m_psc[k] <= p; m_wrap[k] <= w; m_ovf[k] <= o; m_lerr[k] <= e;
         end
      end
   end

   // Compare every instance against the model on the falling edge.
   always @(negedge clock) begin
      if (chk_on) begin
         for (int k = 0; k < 4; k++) begin
            bit exp_tc;
            exp_tc = up ? (m_cnt[k] == mod_of(k) - 1) : (m_cnt[k] == 0);
            chk($sformatf("cnt%0d", k),  32'(cnt_w[k]),  32'(m_cnt[k]));
            chk($sformatf("tc%0d", k),   32'(tc_w[k]),   32'(exp_tc));
            chk($sformatf("wrap%0d", k), 32'(wrap_w[k]), 32'(m_wrap[k]));
            chk($sformatf("ovf%0d", k),  32'(ovf_w[k]),  32'(m_ovf[k]));
            chk($sformatf("lerr%0d", k), 32'(lerr_w[k]), 32'(m_lerr[k]));
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0; up = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      chk_on = 1;
      chk("rst_cnt", 32'(cnt_w[0]), 32'd0);
      chk("rst_ovf", 32'(ovf_w[0]), 32'd0);

      // Async reset mid-count.
      enable = 1'b1; up = 1'b1;
      repeat (7) cyc();
      chk("t1_cnt7", 32'(cnt_w[0]), 32'd7);
      #2 reset = 1'b0;
      #1;
      chk("t1_async_cnt", 32'(cnt_w[0]), 32'd0);
      chk("t1_async_ovf", 32'(ovf_w[0]), 32'd0);
      chk("t1_async_wrap", 32'(wrap_w[0]), 32'd0);
      chk("t1_async_cntc", 32'(cnt_w[2]), 32'd0);
      cyc();
      reset = 1'b1;
      cyc();
      chk("t1_restart_c", 32'(cnt_w[2]), 32'd0);

      // Wrap-mode up count through 9 -> 0.
      clear = 1'b1; cyc(); clear = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("t2_cnt", 32'(cnt_w[0]), 32'((i + 1) % 10));
         chk("t2_wrap", 32'(wrap_w[0]), 32'((i + 1) == 10));
         chk("t2_tc", 32'(tc_w[0]), 32'(((i + 1) % 10) == 9));
      end
      chk("t2_ovf", 32'(ovf_w[0]), 32'd1);

      // Saturating down count from 2.
      up = 1'b0; load_val = 4'd2; load = 1'b1; cyc(); load = 1'b0;
      chk("t3_load", 32'(cnt_w[1]), 32'd2);
      for (int i = 0; i < 5; i++) begin
         int e;
         cyc();
         e = (2 - (i + 1) > 0) ? 2 - (i + 1) : 0;
         chk("t3_cnt", 32'(cnt_w[1]), 32'(e));
         chk("t3_wrap", 32'(wrap_w[1]), 32'(i >= 2));
         chk("t3_tc", 32'(tc_w[1]), 32'(e == 0));
      end

      // Prescale 3 with a two-cycle enable gap.
      up = 1'b1; clear = 1'b1; cyc(); clear = 1'b0;
      repeat (2) cyc();
      chk("t4_c_pre", 32'(cnt_w[2]), 32'd0);
      cyc();
      chk("t4_c_step1", 32'(cnt_w[2]), 32'd1);
      cyc();
      enable = 1'b0; repeat (2) cyc();
      chk("t4_c_hold", 32'(cnt_w[2]), 32'd1);
      enable = 1'b1; cyc();
      chk("t4_c_late", 32'(cnt_w[2]), 32'd1);
      cyc();
      chk("t4_c_step2", 32'(cnt_w[2]), 32'd2);

      // Out-of-range load, then clear beats load.
      enable = 1'b0; load_val = 4'd12; load = 1'b1; cyc(); load = 1'b0;
      chk("t5_cnt9", 32'(cnt_w[0]), 32'd9);
      chk("t5_lerr", 32'(lerr_w[0]), 32'd1);
      chk("t5_d12", 32'(cnt_w[3]), 32'd12);
      chk("t5_d_lerr", 32'(lerr_w[3]), 32'd0);
      enable = 1'b1; cyc(); enable = 1'b0;
      chk("t5_lerr_drop", 32'(lerr_w[0]), 32'd0);
      chk("t5_ovf_set", 32'(ovf_w[0]), 32'd1);
      clear = 1'b1; load = 1'b1; load_val = 4'd5; cyc(); clear = 1'b0; load = 1'b0;
      chk("t5_clr_cnt", 32'(cnt_w[0]), 32'd0);
      chk("t5_clr_ovf", 32'(ovf_w[0]), 32'd0);

      // Full-range wrap 15 -> 0 and live direction toggling.
      load_val = 4'd15; load = 1'b1; cyc(); load = 1'b0;
      chk("t6_d15_tc", 32'(tc_w[3]), 32'd1);
      enable = 1'b1; cyc();
      chk("t6_d_wrap0", 32'(cnt_w[3]), 32'd0);
      chk("t6_d_wrapf", 32'(wrap_w[3]), 32'd1);
      enable = 1'b0;
      up = 1'b1; #1 chk("t6_tc_up", 32'(tc_w[3]), 32'd0);
      up = 1'b0; #1 chk("t6_tc_dn", 32'(tc_w[3]), 32'd1);
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t6_osc", 32'(cnt_w[3]), (i % 2 == 0) ? 32'd15 : 32'd0);
         up = ~up;
      end

      // Mixed traffic, model-checked only.
      for (int i = 0; i < 60; i++) begin
         enable   = 1'($urandom_range(0, 3) != 0);
         up       = 1'($urandom_range(0, 1));
         load     = 1'($urandom_range(0, 9) == 0);
         clear    = 1'($urandom_range(0, 19) == 0);
         load_val = 4'($urandom_range(0, 15));
         cyc();
      end
      clear = 1'b0; load = 1'b0;
      cyc();
      chk_on = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
